clock_text_renderer: RTL and testbench



---
 rtl/clock_text_renderer.sv | 167 ++++++++++++++++
 tb/tb_clock_text_renderer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_text_renderer.sv
// clock_text_renderer
// Keeps an HH:MM:SS time of day and renders it as an 8-character "HH:MM:SS"
// text box on the VGA raster. Pixel coordinates become glyph ROM addresses
// {char_code[6:0], row[3:0]}; the ROM row byte returned one cycle later is
// turned into a registered text_on pixel. x/y -> text_on latency is 3 cycles.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   tick_1hz              one-cycle pulse, advances time by one second
//   set_en, set_hh/mm/ss  load a new time (out-of-range fields load as 0)
//   video_on, x, y        raster position and active-video qualifier
//   rom_addr              registered glyph ROM address
//   rom_data              glyph ROM row, bit 7 = leftmost pixel
//   text_on               registered lit-glyph pixel
//   hh, mm, ss            current time of day
//
// Build option: define COLON_BLINK_EN to blank the colons on odd seconds.
module clock_text_renderer #(
  parameter int unsigned X0          = 256,
  parameter int unsigned Y0          = 16,
  parameter int unsigned SCALE_SHIFT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        set_en,
  input  logic [4:0]  set_hh,
  input  logic [5:0]  set_mm,
  input  logic [5:0]  set_ss,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        text_on,
  output logic [4:0]  hh,
  output logic [5:0]  mm,
  output logic [5:0]  ss
);

  localparam int unsigned BOX_W = 64 << SCALE_SHIFT;
  localparam int unsigned BOX_H = 16 << SCALE_SHIFT;
  localparam logic [10:0] X_LO  = 11'(X0);
  localparam logic [10:0] X_HI  = 11'(X0 + BOX_W);
  localparam logic [10:0] Y_LO  = 11'(Y0);
  localparam logic [10:0] Y_HI  = 11'(Y0 + BOX_H);

  localparam logic [6:0] CODE_DIGIT0 = 7'h30;
  localparam logic [6:0] CODE_COLON  = 7'h3A;

  // Split 0..59 into {tens[2:0], units[3:0]} with compares and one subtract.
  function automatic logic [6:0] split_bcd(input logic [5:0] v);
    logic [2:0] tens;
    logic [5:0] sub;
    if (v >= 6'd50) begin
      tens = 3'd5; sub = 6'd50;
    end else if (v >= 6'd40) begin
      tens = 3'd4; sub = 6'd40;
    end else if (v >= 6'd30) begin
      tens = 3'd3; sub = 6'd30;
    end else if (v >= 6'd20) begin
      tens = 3'd2; sub = 6'd20;
    end else if (v >= 6'd10) begin
      tens = 3'd1; sub = 6'd10;
    end else begin
      tens = 3'd0; sub = 6'd0;
    end
    return {tens, 4'(v - sub)};
  endfunction

  // Time of day; a load wins over a tick in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hh <= 5'd0;
      mm <= 6'd0;
      ss <= 6'd0;
    end else if (set_en) begin
      hh <= (set_hh > 5'd23) ? 5'd0 : set_hh;
      mm <= (set_mm > 6'd59) ? 6'd0 : set_mm;
      ss <= (set_ss > 6'd59) ? 6'd0 : set_ss;
    end else if (tick_1hz) begin
      if (ss == 6'd59) begin
        ss <= 6'd0;
        if (mm == 6'd59) begin
          mm <= 6'd0;
          hh <= (hh == 5'd23) ? 5'd0 : hh + 5'd1;
        end else begin
          mm <= mm + 6'd1;
        end
      end else begin
        ss <= ss + 6'd1;
      end
    end
  end

  // Box-relative coordinates and glyph cell decode.
  logic [9:0] dx, dy;
  logic [5:0] fx;
  logic [3:0] row;
  logic [2:0] char_idx, col;
  logic       in_box;

  assign dx  = x - 10'(X0);
  assign dy  = y - 10'(Y0);
  assign fx  = 6'(dx >> SCALE_SHIFT);
  assign row = 4'(dy >> SCALE_SHIFT);
  assign col = fx[2:0];

  assign in_box = video_on &&
                  ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                  ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);

  // Outside the box the character index clamps to 0; the address still moves.
  assign char_idx = in_box ? fx[5:3] : 3'd0;

  logic [6:0] hh_bcd, mm_bcd, ss_bcd;
  logic [6:0] colon_code;
  logic [6:0] char_code;

  assign hh_bcd = split_bcd({1'b0, hh});
  assign mm_bcd = split_bcd(mm);
  assign ss_bcd = split_bcd(ss);

`ifdef COLON_BLINK_EN
  // Code 0x20 reads as a blank row from the ROM, so colons vanish on odd seconds.
  assign colon_code = ss[0] ? 7'h20 : CODE_COLON;
`else
  assign colon_code = CODE_COLON;
`endif

  // Character code for the "HH:MM:SS" string position.
  always_comb begin
    char_code = colon_code;
    case (char_idx)
      3'd0:    char_code = CODE_DIGIT0 + 7'(hh_bcd[6:4]);
      3'd1:    char_code = CODE_DIGIT0 + 7'(hh_bcd[3:0]);
      3'd3:    char_code = CODE_DIGIT0 + 7'(mm_bcd[6:4]);
      3'd4:    char_code = CODE_DIGIT0 + 7'(mm_bcd[3:0]);
      3'd6:    char_code = CODE_DIGIT0 + 7'(ss_bcd[6:4]);
      3'd7:    char_code = CODE_DIGIT0 + 7'(ss_bcd[3:0]);
      default: char_code = colon_code;
    endcase
  end

  // Three-stage pixel pipeline: address, ROM wait, bit select.
  logic       in_box_d1, in_box_d2;
  logic [2:0] col_d1, col_d2;

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr  <= 11'd0;
      in_box_d1 <= 1'b0;
      col_d1    <= 3'd0;
      in_box_d2 <= 1'b0;
      col_d2    <= 3'd0;
      text_on   <= 1'b0;
    end else begin
      rom_addr  <= {char_code, row};
      in_box_d1 <= in_box;
      col_d1    <= col;
      in_box_d2 <= in_box_d1;
      col_d2    <= col_d1;
      text_on   <= in_box_d2 & rom_data[3'd7 - col_d2];
    end
  end

endmodule

// File: tb/tb_clock_text_renderer.sv
// Self-checking bench for clock_text_renderer (X0=256, Y0=16, SCALE_SHIFT=1).
// A registered ROM model answers rom_addr; a reference model predicts
// rom_addr (1 cycle) and text_on (3 cycles) for every driven pixel and
// queues them as scoreboard entries checked when they fall due.
module tb_clock_text_renderer;

  localparam int X0 = 256;
  localparam int Y0 = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick_1hz = 1'b0;
  logic        set_en = 1'b0;
  logic [4:0]  set_hh = 5'd0;
  logic [5:0]  set_mm = 6'd0;
  logic [5:0]  set_ss = 6'd0;
  logic        video_on = 1'b0;
  logic [9:0]  x = 10'd0;
  logic [9:0]  y = 10'd0;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = 8'd0;
  logic        text_on;
  logic [4:0]  hh;
  logic [5:0]  mm, ss;

  always #5 clk = ~clk;

  clock_text_renderer #(.X0(256), .Y0(16), .SCALE_SHIFT(1)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .set_en(set_en),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .video_on(video_on), .x(x), .y(y), .rom_addr(rom_addr),
    .rom_data(rom_data), .text_on(text_on), .hh(hh), .mm(mm), .ss(ss)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_h = 0, t_m = 0, t_s = 0;
  bit rom_ff = 1'b0;

  typedef struct { int due; logic [10:0] val; } ent_t;
  ent_t aq[$];
  ent_t tq[$];

  function automatic logic [7:0] rom_fn(logic [10:0] a, bit ff);
    int v;
    if (ff) return 8'hFF;
    if (a == 11'h333) return 8'h80;
    v = (int'(a) * 37) ^ (int'(a) >> 3);
    return 8'(v);
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr, rom_ff);

  function automatic void model(input int px, input int py, input bit vid,
                                output logic [10:0] addr, output logic ton);
    int dx, dy, fx, idx, col, row, code;
    bit inb;
    logic [7:0] d;
    inb = vid && px >= X0 && px < X0 + 128 && py >= Y0 && py < Y0 + 32;
    dx  = (px - X0) & 1023;
    dy  = (py - Y0) & 1023;
    fx  = dx >> 1;
    idx = inb ? ((fx >> 3) & 7) : 0;
    col = fx & 7;
    row = (dy >> 1) & 15;
    case (idx)
      0: code = 48 + t_h / 10;
      1: code = 48 + t_h % 10;
      3: code = 48 + t_m / 10;
      4: code = 48 + t_m % 10;
      6: code = 48 + t_s / 10;
      7: code = 48 + t_s % 10;
`ifdef COLON_BLINK_EN
      default: code = (t_s % 2 == 1) ? 'h20 : 'h3A;
`else
      default: code = 'h3A;
`endif
    endcase
    addr = 11'(code * 16 + row);
    d    = rom_fn(addr, rom_ff);
    ton  = inb && d[7 - col];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_check();
    ent_t e;
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      e = aq.pop_front();
      chk("sb_rom_addr", 32'(rom_addr), 32'(e.val));
    end
    while (tq.size() > 0 && tq[0].due <= cyc) begin
      e = tq.pop_front();
      chk("sb_text_on", 32'(text_on), 32'(e.val));
    end
  endtask

  // One clock; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    sb_check();
  endtask

  task automatic drive_px(input int px, input int py, input bit vid);
    logic [10:0] a;
    logic t;
    ent_t e;
    x = 10'(px);
    y = 10'(py);
    video_on = vid;
    model(px, py, vid, a, t);
    e.due = cyc + 1; e.val = a;           aq.push_back(e);
    e.due = cyc + 3; e.val = 11'(t);      tq.push_back(e);
  endtask

  task automatic set_time(input int h, input int m, input int s, input bit tk);
    set_en = 1'b1; tick_1hz = tk;
    set_hh = 5'(h); set_mm = 6'(m); set_ss = 6'(s);
    step();
    set_en = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hh"}, 32'(hh), 32'(h));
    chk({tag, "_mm"}, 32'(mm), 32'(m));
    chk({tag, "_ss"}, 32'(ss), 32'(s));
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    // Reset with the raster sweeping through the box.
    video_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      x = 10'(X0 + i * 20);
      y = 10'(Y0 + 4);
      step();
      chk_time("rst", 0, 0, 0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_text_on", 32'(text_on), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_px(X0 + 40 + i * 2, Y0 + 6, 1'b0);
      step();
      chk("post_rst_text_on", 32'(text_on), 32'd0);
    end
    drain();

    // Timekeeping rollover and load rules.
    set_time(23, 59, 58, 1'b0); chk_time("set_235958", 23, 59, 58);
    pulse_tick();               chk_time("tick_235959", 23, 59, 59);
    pulse_tick();               chk_time("tick_wrap", 0, 0, 0);
    set_time(10, 59, 59, 1'b0);
    pulse_tick();               chk_time("tick_110000", 11, 0, 0);
    set_time(12, 34, 56, 1'b1); chk_time("set_over_tick", 12, 34, 56);
    set_time(30, 5, 7, 1'b0);   chk_time("set_hh_range", 0, 5, 7);
    set_time(3, 60, 61, 1'b0);  chk_time("set_mm_ss_range", 3, 0, 0);

    // Lit pixel of the minutes-tens glyph at 12:34:56.
    set_time(12, 34, 56, 1'b0);
    t_h = 12; t_m = 34; t_s = 56;
    step();
    drive_px(X0 + 48, Y0 + 6, 1'b1);
    step();
    chk("px48_rom_addr", 32'(rom_addr), 32'h333);
    step();
    step();
    chk("px48_text_on", 32'(text_on), 32'd1);
    drive_px(X0 + 50, Y0 + 6, 1'b1);
    step(); step(); step();
    chk("px50_text_on", 32'(text_on), 32'd0);

    // Random raster around the box.
    for (int i = 0; i < 60; i++) begin
      drive_px(int'($urandom_range(420, 200)), int'($urandom_range(60, 0)),
               $urandom_range(3, 0) != 0);
      step();
    end
    drain();

    // Colon code at even/odd seconds.
    set_time(12, 34, 57, 1'b0);
    t_s = 57;
    drive_px(X0 + 32, Y0, 1'b1);
    step();
`ifdef COLON_BLINK_EN
    chk("colon_ss57", 32'(rom_addr[10:4]), 32'h20);
`else
    chk("colon_ss57", 32'(rom_addr[10:4]), 32'h3A);
`endif
    drain();
    set_time(12, 34, 58, 1'b0);
    t_s = 58;
    drive_px(X0 + 32, Y0, 1'b1);
    step();
    chk("colon_ss58", 32'(rom_addr[10:4]), 32'h3A);
    drain();

    // Different time, random raster again.
    set_time(9, 47, 13, 1'b0);
    t_h = 9; t_m = 47; t_s = 13;
    step();
    for (int i = 0; i < 60; i++) begin
      drive_px(int'($urandom_range(400, 240)), int'($urandom_range(52, 10)),
               $urandom_range(5, 0) != 0);
      step();
    end
    drain();

    // ROM forced to all ones: only in-box, active pixels may light.
    rom_ff = 1'b1;
    step();
    drive_px(X0 + 128, Y0 + 6, 1'b1);
    step(); step(); step();
    chk("ff_right_edge", 32'(text_on), 32'd0);
    drive_px(X0 + 48, Y0 - 1, 1'b1);
    step(); step(); step();
    chk("ff_above_top", 32'(text_on), 32'd0);
    drive_px(X0 + 48, Y0 + 6, 1'b0);
    step(); step(); step();
    chk("ff_video_off", 32'(text_on), 32'd0);
    drive_px(X0 + 127, Y0 + 31, 1'b1);
    step(); step(); step();
    chk("ff_last_pixel", 32'(text_on), 32'd1);
    drain();
    rom_ff = 1'b0;
    step();

    // Reset in the middle of a lit stream.
    set_time(12, 34, 56, 1'b0);
    t_h = 12; t_m = 34; t_s = 56;
    for (int i = 0; i < 3; i++) begin
      drive_px(X0 + 48, Y0 + 6, 1'b1);
      step();
    end
    reset = 1'b1;
    aq.delete();
    tq.delete();
    step();
    chk("midrst_text_on", 32'(text_on), 32'd0);
    chk_time("midrst", 0, 0, 0);
    reset = 1'b0;
    t_h = 0; t_m = 0; t_s = 0;
    for (int i = 0; i < 2; i++) begin
      drive_px(X0 + 48, Y0 + 6, 1'b1);
      step();
      chk("midrst_flush", 32'(text_on), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      drive_px(X0 + 48 + i, Y0 + 6, 1'b1);
      step();
    end
    drain();

    chk("sb_empty", 32'(aq.size() + tq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
